mmu_bus_v2: RTL and testbench

Second-generation MMU. It keeps the existing memory map: ROM instruction window, banked byte-lane data RAM, and I/O window. It adds parametrised RAM depth and window bases, a valid/ready request handshake, variable-latency I/O with wait states, and fault reporting for misaligned, unmapped and timed-out accesses. It sits between the core's IM/DM ports and the ROM, data RAM banks and I/O bus.

---
 rtl/mmu_pkg.sv | 21 ++
 rtl/mmu_bus_v2_if.sv | 35 +++
 rtl/BRAM_SSP.sv | 21 ++
 rtl/mmu_load_align.sv | 21 ++
 rtl/mmu_bus_v2.sv | 223 ++++++++++++++++++++++
 tb/tb_mmu_bus_v2.sv | 277 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/mmu_pkg.sv
// Shared types, constants and byte-enable helper for the mmu_bus_v2 slice.
package mmu_pkg;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
  typedef enum logic [1:0] {F_NONE, F_MISALIGN, F_UNMAPPED, F_TIMEOUT} fault_e;
  typedef enum logic [1:0] {IDLE, IO_WAIT, RESP} state_e;
  typedef enum logic [1:0] {R_NONE, R_RAM, R_IO} region_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [3:0] byte_en(size_e sz, logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mmu_bus_v2_if.sv
// Data-port request/response and I/O bus bundle between core and mmu_bus_v2.
interface mmu_bus_v2_if #(
  parameter int unsigned IO_ADDR_W = 8
);
  logic                 dm_valid;
  logic                 dm_ready;
  logic                 dm_we;
  logic [31:0]          dm_addr;
  logic [31:0]          dm_di;
  logic [1:0]           dm_size;
  logic                 is_signed;
  logic                 dm_rvalid;
  logic [31:0]          dm_do;
  logic                 dm_fault;
  logic [1:0]           dm_fault_code;
  logic [IO_ADDR_W-1:0] io_addr;
  logic                 io_en;
  logic                 io_we;
  logic [3:0]           io_be;
  logic [31:0]          io_data_write;
  logic [31:0]          io_data_read;
  logic                 io_ack;

  modport master (
    output dm_valid, dm_we, dm_addr, dm_di, dm_size, is_signed,
    input  dm_ready, dm_rvalid, dm_do, dm_fault, dm_fault_code
  );

  modport slave (
    input  dm_valid, dm_we, dm_addr, dm_di, dm_size, is_signed,
    output dm_ready, dm_rvalid, dm_do, dm_fault, dm_fault_code,
    output io_addr, io_en, io_we, io_be, io_data_write,
    input  io_data_read, io_ack
  );
endinterface

// File: rtl/BRAM_SSP.sv
// Single-port synchronous RAM: one access per enabled cycle, registered read.
module BRAM_SSP #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end
endmodule

// File: rtl/mmu_load_align.sv
// Lane extract and sign/zero extension of a 32-bit load word, shared by RAM and I/O returns.
module mmu_load_align
  import mmu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        sgn_i,
  output logic [31:0] data_o
);
  logic [31:0] shifted;

  always_comb begin
    shifted = data_i >> {off_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_o = {{24{sgn_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{sgn_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end
endmodule

// File: rtl/mmu_bus_v2.sv
// Second-generation MMU: ROM fetch path, banked data RAM, wait-state I/O window with fault reporting.
// Define MMU_IO_TIMEOUT_EN to build the I/O wait-state timeout counter (fault code 3).
module mmu_bus_v2
  import mmu_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] RAM_BASE   = 32'h1000_0000,
  parameter logic [31:0] IO_BASE    = 32'h8000_0000,
  parameter int unsigned IO_ADDR_W  = 8,
  parameter int unsigned ROM_ADDR_W = 12,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           im_addr,
  output logic [ROM_ADDR_W-3:0] im_addr_out,
  input  logic [31:0]           im_data,
  output logic [31:0]           im_do,
  mmu_bus_v2_if.slave           bus
);
  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] IO_BYTES  = 32'(1) << IO_ADDR_W;
  localparam logic [31:0] ROM_BYTES = 32'(1) << ROM_ADDR_W;

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  fault_e               code_q, code_d;
  logic                 we_q, we_d;
  logic [1:0]           off_q, off_d;
  size_e                size_q, size_d;
  logic                 sgn_q, sgn_d;
  logic                 io_en_q, io_en_d;
  logic                 io_we_q, io_we_d;
  logic [IO_ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [3:0]           io_be_q, io_be_d;
  logic [31:0]          io_wdata_q, io_wdata_d;
  logic [31:0]          io_rdata_q, io_rdata_d;
  logic [31:0]          im_do_q;
`ifdef MMU_IO_TIMEOUT_EN
  logic [7:0]           cnt_q, cnt_d;
`endif

  size_e       req_size;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  region_e     region;
  fault_e      req_fault;
  logic        accept;
  logic [31:0] ram_off, io_off;
  logic [3:0]  ram_en;
  logic [31:0] ram_rdata, ld_src, ld_data;
  logic        rvalid;
  logic        unused_im;

  assign im_addr_out = im_addr[ROM_ADDR_W-1:2];
  assign im_do       = im_do_q;
  assign unused_im   = ^{im_addr[31:ROM_ADDR_W], im_addr[1:0]};

  assign ram_off = bus.dm_addr - RAM_BASE;
  assign io_off  = bus.dm_addr - IO_BASE;
  assign accept  = bus.dm_valid && (state_q == IDLE);

  always_comb begin
    case (bus.dm_size)
      2'd0:    req_size = SZ_BYTE;
      2'd1:    req_size = SZ_HALF;
      default: req_size = SZ_WORD;
    endcase
    req_be = byte_en(req_size, bus.dm_addr[1:0]);
    case (req_size)
      SZ_BYTE: req_wdata = {4{bus.dm_di[7:0]}};
      SZ_HALF: req_wdata = {2{bus.dm_di[15:0]}};
      default: req_wdata = bus.dm_di;
    endcase
    // ROM window is never reachable from the data port, even if a base overlaps it
    region = R_NONE;
    if (bus.dm_addr >= ROM_BYTES) begin
      if (ram_off < RAM_BYTES)     region = R_RAM;
      else if (io_off < IO_BYTES)  region = R_IO;
    end
    if ((req_size == SZ_HALF && bus.dm_addr[0]) ||
        (req_size == SZ_WORD && bus.dm_addr[1:0] != 2'b00))
      req_fault = F_MISALIGN;
    else if (region == R_NONE)
      req_fault = F_UNMAPPED;
    else
      req_fault = F_NONE;
  end

  assign ram_en = (accept && req_fault == F_NONE && region == R_RAM) ? req_be : '0;

  for (genvar i = 0; i < 4; i++) begin : g_bank
    BRAM_SSP #(.DEPTH(RAM_WORDS), .WIDTH(8)) u_bank (
      .clk  (clk),
      .en   (ram_en[i]),
      .we   (bus.dm_we),
      .addr (ram_off[RAM_AW+1:2]),
      .din  (req_wdata[8*i +: 8]),
      .dout (ram_rdata[8*i +: 8])
    );
  end

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    code_d     = code_q;
    we_d       = we_q;
    off_d      = off_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    io_en_d    = io_en_q;
    io_we_d    = io_we_q;
    io_addr_d  = io_addr_q;
    io_be_d    = io_be_q;
    io_wdata_d = io_wdata_q;
    io_rdata_d = io_rdata_q;
`ifdef MMU_IO_TIMEOUT_EN
    cnt_d      = (state_q == IO_WAIT) ? cnt_q + 8'd1 : '0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          code_d = req_fault;
          we_d   = bus.dm_we;
          off_d  = bus.dm_addr[1:0];
          size_d = req_size;
          sgn_d  = bus.is_signed;
          if (req_fault == F_NONE && region == R_IO) begin
            state_d    = IO_WAIT;
            io_en_d    = 1'b1;
            io_we_d    = bus.dm_we;
            io_addr_d  = io_off[IO_ADDR_W-1:0];
            io_be_d    = req_be;
            io_wdata_d = req_wdata;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      IO_WAIT: begin
        if (bus.io_ack) begin
          io_rdata_d = bus.io_data_read;
          io_en_d    = 1'b0;
          io_we_d    = 1'b0;
          state_d    = RESP;
        end
`ifdef MMU_IO_TIMEOUT_EN
        else if (cnt_q == 8'(IO_TIMEOUT - 1)) begin
          io_en_d = 1'b0;
          io_we_d = 1'b0;
          code_d  = F_TIMEOUT;
          state_d = RESP;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      code_q     <= F_NONE;
      we_q       <= 1'b0;
      off_q      <= '0;
      size_q     <= SZ_BYTE;
      sgn_q      <= 1'b0;
      io_en_q    <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_be_q    <= '0;
      io_wdata_q <= '0;
      io_rdata_q <= '0;
      im_do_q    <= NOP;
`ifdef MMU_IO_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      code_q     <= code_d;
      we_q       <= we_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      io_en_q    <= io_en_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_be_q    <= io_be_d;
      io_wdata_q <= io_wdata_d;
      io_rdata_q <= io_rdata_d;
      im_do_q    <= im_data;
`ifdef MMU_IO_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // RAM completions stay in IDLE (done_q); I/O completions are the RESP state
  assign ld_src = (state_q == RESP) ? io_rdata_q : ram_rdata;
  assign rvalid = done_q || (state_q == RESP);

  mmu_load_align u_align (
    .data_i (ld_src),
    .off_i  (off_q),
    .size_i (size_q),
    .sgn_i  (sgn_q),
    .data_o (ld_data)
  );

  assign bus.dm_ready      = (state_q == IDLE);
  assign bus.dm_rvalid     = rvalid;
  assign bus.dm_fault      = rvalid && (code_q != F_NONE);
  assign bus.dm_fault_code = rvalid ? code_q : F_NONE;
  assign bus.dm_do         = (rvalid && code_q == F_NONE && !we_q) ? ld_data : '0;
  assign bus.io_en         = io_en_q;
  assign bus.io_we         = io_we_q;
  assign bus.io_addr       = io_addr_q;
  assign bus.io_be         = io_be_q;
  assign bus.io_data_write = io_wdata_q;
endmodule

// File: tb/tb_mmu_bus_v2.sv
// Scoreboard bench for mmu_bus_v2: directed requests queue expectations, a monitor checks completions.
module tb_mmu_bus_v2;
  logic        clk;
  logic        reset;
  logic [31:0] im_addr;
  logic [9:0]  im_addr_out;
  logic [31:0] im_data;
  logic [31:0] im_do;

  mmu_bus_v2_if #(.IO_ADDR_W(8)) bus ();

  mmu_bus_v2 #(.IO_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .im_addr     (im_addr),
    .im_addr_out (im_addr_out),
    .im_data     (im_data),
    .im_do       (im_do),
    .bus         (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic [1:0]  code;
    int          lat;
    logic        rdy;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  // I/O responder controls and observations
  int          ack_at   = 0;
  logic        spurious = 1'b0;
  logic [31:0] io_rd_val = '0;
  int          io_run   = 0;
  int          io_last  = 0;
  logic        io_prev  = 1'b0;
  logic [7:0]  first_addr, last_addr;
  logic [3:0]  first_be, last_be;
  logic        first_we;
  logic [31:0] first_wd, last_wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.io_en) begin
      io_run++;
      if (io_run == 1) begin
        first_addr = bus.io_addr;
        first_be   = bus.io_be;
        first_we   = bus.io_we;
        first_wd   = bus.io_data_write;
      end
      last_addr = bus.io_addr;
      last_be   = bus.io_be;
      last_wd   = bus.io_data_write;
      bus.io_ack       = (ack_at != 0) && (io_run == ack_at);
      bus.io_data_read = io_rd_val;
    end else begin
      if (io_prev) io_last = io_run;
      io_run           = 0;
      bus.io_ack       = spurious;
      bus.io_data_read = 32'h5A5A_0000;
    end
    io_prev = bus.io_en;
  end

  always @(negedge clk) begin
    if (!reset && bus.dm_rvalid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rvalid: got dm_do=%08h code=%0d with nothing outstanding",
                 bus.dm_do, bus.dm_fault_code);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.nm, "_do"},    bus.dm_do, mon_e.d);
        chk({mon_e.nm, "_code"},  32'(bus.dm_fault_code), 32'(mon_e.code));
        chk({mon_e.nm, "_fault"}, 32'(bus.dm_fault), 32'(mon_e.code != 2'd0));
        chk({mon_e.nm, "_lat"},   32'(cyc - mon_e.acc), 32'(mon_e.lat));
        chk({mon_e.nm, "_ready"}, 32'(bus.dm_ready), 32'(mon_e.rdy));
      end
    end
  end

  // lat = clock edges between the accepting edge and the edge that raises dm_rvalid
  task automatic issue(input string nm, input bit we, input logic [31:0] a, input logic [31:0] di,
                       input logic [1:0] sz, input bit sg, input logic [31:0] ed,
                       input logic [1:0] ec, input int lat, input bit rdy);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.dm_valid  = 1'b1;
    bus.dm_we     = we;
    bus.dm_addr   = a;
    bus.dm_di     = di;
    bus.dm_size   = sz;
    bus.is_signed = sg;
    n = 0;
    while (!bus.dm_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.dm_ready) begin
      compared++;
      mismatched++;
      $display("FAIL %s_accept: got dm_ready=0 after %0d cycles, expected 1", nm, n);
      bus.dm_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.nm = nm; e.d = ed; e.code = ec; e.lat = lat; e.rdy = rdy; e.acc = cyc;
    exp_q.push_back(e);
    bus.dm_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    im_addr = '0; im_data = '0;
    bus.dm_valid = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_di = '0;
    bus.dm_size = 2'd0; bus.is_signed = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_im_do",  im_do, 32'h0000_0013);
    chk("rst_rvalid", 32'(bus.dm_rvalid), 32'd0);
    chk("rst_fault",  32'(bus.dm_fault), 32'd0);
    chk("rst_code",   32'(bus.dm_fault_code), 32'd0);
    chk("rst_do",     bus.dm_do, 32'd0);
    chk("rst_io_en",  32'(bus.io_en), 32'd0);
    chk("rst_io_we",  32'(bus.io_we), 32'd0);
    chk("rst_io_be",  32'(bus.io_be), 32'd0);
    chk("rst_io_addr", 32'(bus.io_addr), 32'd0);
    chk("rst_io_wd",  bus.io_data_write, 32'd0);
    chk("rst_ready",  32'(bus.dm_ready), 32'd1);
    reset = 1'b0;

    im_addr = 32'h0000_0ABC;
    im_data = 32'hCAFE_BABE;
    @(posedge clk); #1;
    chk("im_do",       im_do, 32'hCAFE_BABE);
    chk("im_addr_out", 32'(im_addr_out), 32'h2AF);

    // RAM word store/load back-to-back
    issue("st_w",   1, 32'h1000_0004, 32'hDEAD_BEEF, 2'd2, 1, 32'h0,         2'd0, 0, 1);
    issue("ld_w",   0, 32'h1000_0004, 32'h0,         2'd2, 1, 32'hDEAD_BEEF, 2'd0, 0, 1);
    // byte lane store, then signed/unsigned extraction
    issue("st_b",   1, 32'h1000_0007, 32'h0000_0080, 2'd0, 0, 32'h0,         2'd0, 0, 1);
    issue("ld_bs",  0, 32'h1000_0007, 32'h0,         2'd0, 1, 32'hFFFF_FF80, 2'd0, 0, 1);
    issue("ld_bu",  0, 32'h1000_0007, 32'h0,         2'd0, 0, 32'h0000_0080, 2'd0, 0, 1);
    issue("ld_wb",  0, 32'h1000_0004, 32'h0,         2'd2, 0, 32'h80AD_BEEF, 2'd0, 0, 1);
    issue("ld_hs",  0, 32'h1000_0004, 32'h0,         2'd1, 1, 32'hFFFF_BEEF, 2'd0, 0, 1);
    issue("ld_hu",  0, 32'h1000_0006, 32'h0,         2'd1, 0, 32'h0000_80AD, 2'd0, 0, 1);
    issue("ld_b5",  0, 32'h1000_0005, 32'h0,         2'd0, 0, 32'h0000_00BE, 2'd0, 0, 1);
    issue("st_w8",  1, 32'h1000_0008, 32'h0,         2'd2, 0, 32'h0,         2'd0, 0, 1);
    issue("st_h",   1, 32'h1000_000A, 32'h0000_1234, 2'd1, 0, 32'h0,         2'd0, 0, 1);
    issue("ld_w8",  0, 32'h1000_0008, 32'h0,         2'd2, 0, 32'h1234_0000, 2'd0, 0, 1);
    // faults and window boundaries
    issue("mis_h",  0, 32'h1000_0001, 32'h0,         2'd1, 0, 32'h0,         2'd1, 0, 1);
    issue("mis_st", 1, 32'h1000_0005, 32'h1111_1111, 2'd2, 0, 32'h0,         2'd1, 0, 1);
    issue("ld_keep",0, 32'h1000_0004, 32'h0,         2'd2, 0, 32'h80AD_BEEF, 2'd0, 0, 1);
    issue("rom_w",  0, 32'h0000_0010, 32'h0,         2'd2, 0, 32'h0,         2'd2, 0, 1);
    issue("hole_w", 0, 32'h4000_0000, 32'h0,         2'd2, 0, 32'h0,         2'd2, 0, 1);
    issue("st_top", 1, 32'h1000_0FFC, 32'hA5A5_5A5A, 2'd2, 0, 32'h0,         2'd0, 0, 1);
    issue("ld_top", 0, 32'h1000_0FFC, 32'h0,         2'd2, 0, 32'hA5A5_5A5A, 2'd0, 0, 1);
    issue("ram_end",0, 32'h1000_1000, 32'h0,         2'd2, 0, 32'h0,         2'd2, 0, 1);
    issue("io_end", 0, 32'h8000_0100, 32'h0,         2'd0, 0, 32'h0,         2'd2, 0, 1);
    issue("sz3",    0, 32'h1000_0004, 32'h0,         2'd3, 0, 32'h80AD_BEEF, 2'd0, 0, 1);
    issue("sz3_mis",0, 32'h1000_0006, 32'h0,         2'd3, 0, 32'h0,         2'd1, 0, 1);
    drain();

    // I/O store acknowledged in the third wait cycle
    ack_at = 3;
    issue("io_st",  1, 32'h8000_0010, 32'h1122_3344, 2'd2, 0, 32'h0,         2'd0, 3, 0);
    drain();
    chk("io_st_cycles", 32'(io_last), 32'd3);
    chk("io_st_addr",   32'(first_addr), 32'h10);
    chk("io_st_be",     32'(first_be), 32'hF);
    chk("io_st_we",     32'(first_we), 32'd1);
    chk("io_st_wd",     first_wd, 32'h1122_3344);
    chk("io_st_addr_hold", 32'(last_addr), 32'h10);
    chk("io_st_wd_hold",   last_wd, 32'h1122_3344);

    // I/O byte load with io_ack held high while idle
    ack_at = 1; spurious = 1'b1; io_rd_val = 32'h9A00_0000;
    issue("io_ldb", 0, 32'h8000_0013, 32'h0,         2'd0, 1, 32'hFFFF_FF9A, 2'd0, 1, 0);
    drain();
    spurious = 1'b0;
    chk("io_ldb_be",   32'(first_be), 32'h8);
    chk("io_ldb_addr", 32'(first_addr), 32'h13);
    chk("io_ldb_we",   32'(first_we), 32'd0);

    ack_at = 2;
    issue("io_sth", 1, 32'h8000_0012, 32'h0000_ABCD, 2'd1, 0, 32'h0,         2'd0, 2, 0);
    drain();
    chk("io_sth_be", 32'(first_be), 32'hC);
    chk("io_sth_wd", first_wd, 32'hABCD_ABCD);

    ack_at = 1; io_rd_val = 32'h0102_0304;
    issue("io_top", 0, 32'h8000_00FC, 32'h0,         2'd2, 0, 32'h0102_0304, 2'd0, 1, 0);
    drain();

`ifdef MMU_IO_TIMEOUT_EN
    ack_at = 0;
    issue("io_to",  0, 32'h8000_0020, 32'h0,         2'd2, 0, 32'h0,         2'd3, 4, 0);
    drain();
    chk("io_to_cycles", 32'(io_last), 32'd4);
    ack_at = 4; io_rd_val = 32'h5555_AAAA;
    issue("io_ack_exp", 0, 32'h8000_0020, 32'h0,     2'd2, 0, 32'h5555_AAAA, 2'd0, 4, 0);
    drain();
`else
    ack_at = 20; io_rd_val = 32'h5555_AAAA;
    issue("io_long", 0, 32'h8000_0020, 32'h0,        2'd2, 0, 32'h5555_AAAA, 2'd0, 20, 0);
    drain();
    chk("io_long_cycles", 32'(io_last), 32'd20);
`endif

    // reset in the middle of an I/O wait aborts without a completion
    ack_at = 0;
    issue("io_abort", 0, 32'h8000_0040, 32'h0,       2'd2, 0, 32'h0,         2'd0, 0, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("abort_io_en",  32'(bus.io_en), 32'd0);
    chk("abort_rvalid", 32'(bus.dm_rvalid), 32'd0);
    chk("abort_im_do",  im_do, 32'h0000_0013);
    chk("abort_ready",  32'(bus.dm_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    issue("post_rst", 0, 32'h1000_0004, 32'h0,       2'd2, 0, 32'h80AD_BEEF, 2'd0, 0, 1);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
